// File: rtl/serial_add64_ctrl_pkg.sv
// Shared definitions for the nibble-serial 64-bit adder controller:
// default widths, derived slice count and the FSM state encoding.
package serial_add64_ctrl_pkg;

  localparam int WIDTH_DEF  = 64;
  localparam int SLICE_DEF  = 4;
  localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add64_ctrl_add4_slice.sv
// Combinational SLICE-bit ripple-carry adder built from a chain of 1-bit
// full adders; the controller time-shares one instance across all slices.
module add4_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/serial_add64_ctrl.sv
// Multi-cycle WIDTH-bit adder: one SLICE-bit adder processes one slice per
// clock, LSB slice first, between a start handshake and a result handshake.
module serial_add64_ctrl
  import serial_add64_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high. start_ready is high only in IDLE and res_valid only in DONE;
  // both are registered, so neither depends combinationally on the other side.

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             start_ready_q, start_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

  logic [SLICE-1:0] slice_s;
  logic             slice_co;

  add4_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_sh_q[SLICE-1:0]),
    .b    (b_sh_q[SLICE-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_co)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_sh_d        = a_sh_q;
    b_sh_d        = b_sh_q;
    carry_d       = carry_q;
    sum_d         = sum_q;
    c_out_d       = c_out_q;
    ovf_d         = ovf_q;
    a_msb_d       = a_msb_q;
    b_msb_d       = b_msb_q;
    start_ready_d = start_ready_q;
    res_valid_d   = res_valid_q;
    busy_d        = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_valid && start_ready_q) begin
          a_sh_d        = a;
          b_sh_d        = b;
          carry_d       = c_in;
          a_msb_d       = a[WIDTH-1];
          b_msb_d       = b[WIDTH-1];
          cnt_d         = '0;
          state_d       = ST_RUN;
          start_ready_d = 1'b0;
          busy_d        = 1'b1;
        end
      end
      ST_RUN: begin
        // After NSLICE shifts the first slice result lands in the low bits.
        sum_d   = {slice_s, sum_q[WIDTH-1:SLICE]};
        a_sh_d  = a_sh_q >> SLICE;
        b_sh_d  = b_sh_q >> SLICE;
        carry_d = slice_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_DONE;
          c_out_d     = slice_co;
          ovf_d       = (a_msb_q == b_msb_q) && (slice_s[SLICE-1] != a_msb_q);
          res_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d       = ST_IDLE;
          res_valid_d   = 1'b0;
          start_ready_d = 1'b1;
          busy_d        = 1'b0;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        res_valid_d   = 1'b0;
        start_ready_d = 1'b1;
        busy_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      a_sh_q        <= '0;
      b_sh_q        <= '0;
      carry_q       <= 1'b0;
      sum_q         <= '0;
      c_out_q       <= 1'b0;
      ovf_q         <= 1'b0;
      a_msb_q       <= 1'b0;
      b_msb_q       <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      a_sh_q        <= a_sh_d;
      b_sh_q        <= b_sh_d;
      carry_q       <= carry_d;
      sum_q         <= sum_d;
      c_out_q       <= c_out_d;
      ovf_q         <= ovf_d;
      a_msb_q       <= a_msb_d;
      b_msb_q       <= b_msb_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign sum         = sum_q;
  assign c_out       = c_out_q;
  assign overflow    = ovf_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_serial_add64_ctrl.sv
// Bench for serial_add64_ctrl: directed corner cases plus randomized
// back-to-back traffic checked against a plain-arithmetic adder model.
module tb_serial_add64_ctrl;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        c_in;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] sum;
  logic        c_out;
  logic        overflow;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries are {overflow, c_out, sum}.
  logic [65:0] exp_q[$];

  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

  serial_add64_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .c_out       (c_out),
    .overflow    (overflow),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Unsigned result from 65-bit arithmetic; overflow from whether the true
  // signed sum fits in the 64-bit two's-complement range.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic ci);
    logic [64:0]        u;
    logic signed [65:0] s;
    logic               ov;
    u  = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    s  = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, ci});
    ov = (s > SMAX) || (s < SMIN);
    return {ov, u[64], u[63:0]};
  endfunction

  function automatic logic [63:0] rand64();
    logic [63:0] r;
    case ($urandom_range(0, 7))
      0:       r = 64'hFFFF_FFFF_FFFF_FFFF;
      1:       r = 64'h8000_0000_0000_0000;
      2:       r = 64'h7FFF_FFFF_FFFF_FFFF;
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({start_ready, res_valid, busy, c_out, overflow, dbg_state, sum} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0}) begin
      bad++;
      $display("FAIL reset_in: got rdy=%0b vld=%0b busy=%0b co=%0b ov=%0b st=%0d sum=%h want 1 0 0 0 0 0 0",
               start_ready, res_valid, busy, c_out, overflow, dbg_state, sum);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({start_ready, res_valid, busy, dbg_state} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL reset_out: got rdy=%0b vld=%0b busy=%0b st=%0d want 1 0 0 0",
               start_ready, res_valid, busy, dbg_state);
    end
  endtask

  // One operation: start handshake, latency check, optional result stall with
  // start_valid held high, then result handshake and return to IDLE.
  task automatic run_one(input logic [63:0] ta, input logic [63:0] tb_v, input logic tc,
                         input int hold, input logic keep_sv, input string nm);
    logic [65:0] exp;
    int          lat;
    exp_q.push_back(model(ta, tb_v, tc));
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; start_valid = 1'b1; res_ready = 1'b0;
    total++;
    if (start_ready !== 1'b1) begin
      bad++; $display("FAIL %s_idle_ready: got=%0b want=1", nm, start_ready);
    end
    @(posedge clk);
    @(negedge clk);
    start_valid = keep_sv;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'($urandom_range(0, 1));
    lat = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      if (keep_sv) begin
        total++;
        if (start_ready !== 1'b0) begin
          bad++; $display("FAIL %s_run_ready: got=%0b want=0 at cycle %0d", nm, start_ready, lat);
        end
      end
      @(negedge clk);
      lat++;
    end
    exp = exp_q.pop_front();
    total++;
    if (lat != 16) begin
      bad++; $display("FAIL %s_latency: got=%0d want=16", nm, lat);
    end
    if (res_valid === 1'b1) begin
      total++;
      if ({overflow, c_out, sum} !== exp) begin
        bad++; $display("FAIL %s_result: got ov=%0b co=%0b sum=%h want ov=%0b co=%0b sum=%h",
                        nm, overflow, c_out, sum, exp[65], exp[64], exp[63:0]);
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        total++;
        if ({res_valid, start_ready, busy, overflow, c_out, sum} !==
            {1'b1, 1'b0, 1'b1, exp}) begin
          bad++; $display("FAIL %s_stall%0d: got vld=%0b rdy=%0b busy=%0b ov=%0b co=%0b sum=%h",
                          nm, i, res_valid, start_ready, busy, overflow, c_out, sum);
        end
      end
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0; res_ready = 1'b0;
      total++;
      if ({start_ready, res_valid, busy, overflow, c_out, sum} !==
          {1'b1, 1'b0, 1'b0, exp}) begin
        bad++; $display("FAIL %s_back_idle: got rdy=%0b vld=%0b busy=%0b ov=%0b co=%0b sum=%h",
                        nm, start_ready, res_valid, busy, overflow, c_out, sum);
      end
    end else begin
      start_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic test_zero();
    run_one(64'd0, 64'd0, 1'b0, 0, 1'b0, "zero");
  endtask

  task automatic test_carry_ripple();
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0, "ripple");
  endtask

  task automatic test_signed_overflow();
    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0, "pos_ovf");
    run_one(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, 1'b0, "neg_ovf");
  endtask

  task automatic test_stall();
    run_one(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 5, 1'b1, "stall");
  endtask

  task automatic test_reset_mid_run();
    logic seen_rv;
    @(negedge clk);
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'b1;
    start_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    total++;
    if ({busy, res_valid, start_ready} !== 3'b100) begin
      bad++; $display("FAIL midrst_running: got busy=%0b vld=%0b rdy=%0b want 1 0 0",
                      busy, res_valid, start_ready);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({start_ready, res_valid, busy, c_out, overflow, dbg_state, sum} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0}) begin
      bad++; $display("FAIL midrst_async: got rdy=%0b vld=%0b busy=%0b co=%0b ov=%0b st=%0d sum=%h",
                      start_ready, res_valid, busy, c_out, overflow, dbg_state, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_rv = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen_rv = 1'b1;
    end
    total++;
    if (seen_rv !== 1'b0) begin
      bad++; $display("FAIL midrst_no_result: got res_valid seen=%0b want=0", seen_rv);
    end
    res_ready = 1'b0;
    run_one(rand64(), rand64(), 1'($urandom_range(0, 1)), 0, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back(input int nops);
    int          n, n_hs, prev_hs, w;
    logic        abort;
    logic [63:0] ra, rb;
    logic        rc;
    logic [65:0] exp;
    n = 0; prev_hs = -1; abort = 1'b0;
    start_valid = 1'b1; res_ready = 1'b1;
    for (int k = 0; k < nops && !abort; k++) begin
      @(negedge clk); n++;
      w = 0;
      while (start_ready !== 1'b1 && w < 40) begin @(negedge clk); n++; w++; end
      if (w >= 40) begin
        total++; bad++; abort = 1'b1;
        $display("FAIL b2b_ready_timeout: op %0d start_ready stuck at %0b", k, start_ready);
      end else begin
        ra = rand64(); rb = rand64(); rc = 1'($urandom_range(0, 1));
        a = ra; b = rb; c_in = rc;
        exp_q.push_back(model(ra, rb, rc));
        n_hs = n;
        if (prev_hs >= 0) begin
          total++;
          if (n_hs - prev_hs != 18) begin
            bad++; $display("FAIL b2b_spacing: op %0d got=%0d want=18", k, n_hs - prev_hs);
          end
        end
        prev_hs = n_hs;
        w = 0;
        do begin @(negedge clk); n++; w++; end while (res_valid !== 1'b1 && w < 40);
        exp = exp_q.pop_front();
        total++;
        if (res_valid !== 1'b1) begin
          bad++; abort = 1'b1;
          $display("FAIL b2b_result_timeout: op %0d res_valid=%0b", k, res_valid);
        end else if ({overflow, c_out, sum} !== exp) begin
          bad++;
          $display("FAIL b2b_result: op %0d a=%h b=%h ci=%0b got ov=%0b co=%0b sum=%h want ov=%0b co=%0b sum=%h",
                   k, ra, rb, rc, overflow, c_out, sum, exp[65], exp[64], exp[63:0]);
        end
        if (k == nops - 1) start_valid = 1'b0;
      end
    end
    start_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_zero();
    test_carry_ripple();
    test_signed_overflow();
    test_stall();
    test_reset_mid_run();
    test_back_to_back(1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
